// File: rtl/rice_core_id_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads operands with write-back
// bypass, and registers the decode result consumed by EX (1-cycle latency).
module rice_core_id_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_if_valid,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_inst,
  output logic            o_if_stall,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  input  logic [XLEN-1:0] i_rs1_value,
  input  logic [XLEN-1:0] i_rs2_value,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_value,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_pc,
  output logic [31:0]     o_id_inst,
  output logic [4:0]      o_id_rs1,
  output logic [4:0]      o_id_rs2,
  output logic [4:0]      o_id_rd,
  output logic [XLEN-1:0] o_id_rs1_value,
  output logic [XLEN-1:0] o_id_rs2_value,
  output logic [XLEN-1:0] o_id_imm,
  output logic [3:0]      o_id_alu_op,
  output logic            o_id_jal,
  output logic            o_id_jalr,
  output logic            o_id_br_eq_ge,
  output logic            o_id_br_ne_lt,
  output logic [1:0]      o_id_mem_type,
  output logic [2:0]      o_id_mem_size,
  output logic [2:0]      o_id_csr_access,
  output logic            o_id_ecall,
  output logic            o_id_ebreak,
  output logic            o_id_mret,
  output logic            o_id_illegal
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_IMM = 4'd10, ALU_PCIMM = 4'd11,
                         ALU_PC4 = 4'd12;
  localparam logic [4:0] OPC_LOAD = 5'b00000, OPC_FENCE = 5'b00011, OPC_OPIMM = 5'b00100,
                         OPC_AUIPC = 5'b00101, OPC_STORE = 5'b01000, OPC_OP = 5'b01100,
                         OPC_LUI = 5'b01101, OPC_BRANCH = 5'b11000, OPC_JALR = 5'b11001,
                         OPC_JAL = 5'b11011, OPC_SYSTEM = 5'b11100;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            jal;
    logic            jalr;
    logic            br_eq_ge;
    logic            br_ne_lt;
    logic [1:0]      mem_type;
    logic [2:0]      mem_size;
    logic [2:0]      csr_access;
    logic            ecall;
    logic            ebreak;
    logic            mret;
    logic            illegal;
  } id_t;

  id_t             r_id;
  id_t             w_dec;
  logic [4:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_legal, w_use_rs1, w_use_rs2, w_use_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opc = i_if_inst[6:2];
  assign w_f3  = i_if_inst[14:12];
  assign w_f7  = i_if_inst[31:25];

  assign w_imm_i = XLEN'($signed(i_if_inst[31:20]));
  assign w_imm_s = XLEN'($signed({i_if_inst[31:25], i_if_inst[11:7]}));
  assign w_imm_b = XLEN'($signed({i_if_inst[31], i_if_inst[7], i_if_inst[30:25],
                                  i_if_inst[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_if_inst[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({i_if_inst[31], i_if_inst[19:12], i_if_inst[20],
                                  i_if_inst[30:21], 1'b0}));

  assign o_if_stall = i_stall;
  assign o_rs1      = i_if_inst[19:15];
  assign o_rs2      = i_if_inst[24:20];

  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // x0 reads as zero; a same-cycle write-back wins over the regfile read
  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] idx, input logic [XLEN-1:0] rf,
                                             input logic wbv, input logic [4:0] wbrd,
                                             input logic [XLEN-1:0] wbval);
    if (idx == 5'd0)                return '0;
    else if (wbv && wbrd == idx)    return wbval;
    else                            return rf;
  endfunction

  always_comb begin
    w_dec     = '0;
    w_legal   = 1'b1;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    case (w_opc)
      OPC_LUI:   begin w_use_rd = 1'b1; w_dec.imm = w_imm_u; w_dec.alu_op = ALU_IMM; end
      OPC_AUIPC: begin w_use_rd = 1'b1; w_dec.imm = w_imm_u; w_dec.alu_op = ALU_PCIMM; end
      OPC_JAL: begin
        w_use_rd = 1'b1; w_dec.imm = w_imm_j; w_dec.alu_op = ALU_PC4; w_dec.jal = 1'b1;
      end
      OPC_JALR: begin
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_dec.imm = w_imm_i;
        w_dec.alu_op = ALU_PC4; w_dec.jalr = 1'b1; w_legal = (w_f3 == 3'd0);
      end
      OPC_BRANCH: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.imm = w_imm_b;
        case (w_f3)
          3'd0:    begin w_dec.alu_op = ALU_SUB;  w_dec.br_eq_ge = 1'b1; end
          3'd1:    begin w_dec.alu_op = ALU_SUB;  w_dec.br_ne_lt = 1'b1; end
          3'd4:    begin w_dec.alu_op = ALU_SLT;  w_dec.br_ne_lt = 1'b1; end
          3'd5:    begin w_dec.alu_op = ALU_SLT;  w_dec.br_eq_ge = 1'b1; end
          3'd6:    begin w_dec.alu_op = ALU_SLTU; w_dec.br_ne_lt = 1'b1; end
          3'd7:    begin w_dec.alu_op = ALU_SLTU; w_dec.br_eq_ge = 1'b1; end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_dec.imm = w_imm_i;
        w_dec.mem_type = 2'd1; w_dec.mem_size = w_f3;
        w_legal = !(w_f3 == 3'd3 || w_f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.imm = w_imm_s;
        w_dec.mem_type = 2'd2; w_dec.mem_size = w_f3; w_legal = (w_f3 <= 3'd2);
      end
      OPC_OPIMM: begin
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_dec.imm = w_imm_i; w_dec.alu_op = f3_alu(w_f3);
        if (w_f3 == 3'd1) w_legal = (w_f7 == 7'h00);
        if (w_f3 == 3'd5) begin
          w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
          if (w_f7[5]) w_dec.alu_op = ALU_SRA;
        end
      end
      OPC_OP: begin
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.alu_op = f3_alu(w_f3);
        if (w_f7 == 7'h20) begin
          if (w_f3 == 3'd0)      w_dec.alu_op = ALU_SUB;
          else if (w_f3 == 3'd5) w_dec.alu_op = ALU_SRA;
          else                   w_legal = 1'b0;
        end else if (w_f7 != 7'h00) begin
          w_legal = 1'b0;
        end
      end
      OPC_FENCE: w_legal = (w_f3 == 3'd0);
      OPC_SYSTEM: begin
        if (w_f3 == 3'd0) begin
          // trap-class ops are only recognised from their exact encodings
          if (i_if_inst == 32'h0000_0073)      w_dec.ecall  = 1'b1;
          else if (i_if_inst == 32'h0010_0073) w_dec.ebreak = 1'b1;
          else if (i_if_inst == 32'h3020_0073) w_dec.mret   = 1'b1;
          else                                 w_legal      = 1'b0;
        end else if (w_f3 == 3'd4) begin
          w_legal = 1'b0;
        end else begin
          w_use_rd = 1'b1; w_dec.csr_access = w_f3;
          if (w_f3[2]) w_dec.imm = XLEN'(i_if_inst[19:15]);
          else         w_use_rs1 = 1'b1;
        end
      end
      default: w_legal = 1'b0;
    endcase
    if (i_if_inst[1:0] != 2'b11) w_legal = 1'b0;
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
      w_use_rs1     = 1'b0;
      w_use_rs2     = 1'b0;
      w_use_rd      = 1'b0;
    end
    w_dec.valid     = 1'b1;
    w_dec.pc        = i_if_pc;
    w_dec.inst      = i_if_inst;
    w_dec.rs1       = w_use_rs1 ? i_if_inst[19:15] : 5'd0;
    w_dec.rs2       = w_use_rs2 ? i_if_inst[24:20] : 5'd0;
    w_dec.rd        = w_use_rd  ? i_if_inst[11:7]  : 5'd0;
    w_dec.rs1_value = rd_reg(w_dec.rs1, i_rs1_value, i_wb_valid, i_wb_rd, i_wb_value);
    w_dec.rs2_value = rd_reg(w_dec.rs2, i_rs2_value, i_wb_valid, i_wb_rd, i_wb_value);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_enable) begin
      r_id <= '0;
    end else if (i_flush) begin
      r_id.valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_if_valid) r_id <= w_dec;
      else            r_id.valid <= 1'b0;
    end
  end

  assign o_id_valid      = r_id.valid;
  assign o_id_pc         = r_id.pc;
  assign o_id_inst       = r_id.inst;
  assign o_id_rs1        = r_id.rs1;
  assign o_id_rs2        = r_id.rs2;
  assign o_id_rd         = r_id.rd;
  assign o_id_rs1_value  = r_id.rs1_value;
  assign o_id_rs2_value  = r_id.rs2_value;
  assign o_id_imm        = r_id.imm;
  assign o_id_alu_op     = r_id.alu_op;
  assign o_id_jal        = r_id.jal;
  assign o_id_jalr       = r_id.jalr;
  assign o_id_br_eq_ge   = r_id.br_eq_ge;
  assign o_id_br_ne_lt   = r_id.br_ne_lt;
  assign o_id_mem_type   = r_id.mem_type;
  assign o_id_mem_size   = r_id.mem_size;
  assign o_id_csr_access = r_id.csr_access;
  assign o_id_ecall      = r_id.ecall;
  assign o_id_ebreak     = r_id.ebreak;
  assign o_id_mret       = r_id.mret;
  assign o_id_illegal    = r_id.illegal;
endmodule

// File: tb/tb_rice_core_id_stage.sv
// Bench for rice_core_id_stage: directed cases then randomized traffic against a
// mnemonic-level decode model and a pipeline-register model.
module tb_rice_core_id_stage;
  logic        clk = 1'b0;
  logic        i_rst_n, i_enable, i_if_valid, i_stall, i_flush, i_wb_valid;
  logic [31:0] i_if_pc, i_if_inst, i_rs1_value, i_rs2_value, i_wb_value;
  logic [4:0]  i_wb_rd;
  logic        o_if_stall, o_id_valid, o_id_jal, o_id_jalr, o_id_br_eq_ge, o_id_br_ne_lt;
  logic        o_id_ecall, o_id_ebreak, o_id_mret, o_id_illegal;
  logic [4:0]  o_rs1, o_rs2, o_id_rs1, o_id_rs2, o_id_rd;
  logic [31:0] o_id_pc, o_id_inst, o_id_rs1_value, o_id_rs2_value, o_id_imm;
  logic [3:0]  o_id_alu_op;
  logic [1:0]  o_id_mem_type;
  logic [2:0]  o_id_mem_size, o_id_csr_access;

  rice_core_id_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_if_valid(i_if_valid),
    .i_if_pc(i_if_pc), .i_if_inst(i_if_inst), .o_if_stall(o_if_stall), .i_stall(i_stall),
    .i_flush(i_flush), .o_rs1(o_rs1), .o_rs2(o_rs2), .i_rs1_value(i_rs1_value),
    .i_rs2_value(i_rs2_value), .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
    .i_wb_value(i_wb_value), .o_id_valid(o_id_valid), .o_id_pc(o_id_pc),
    .o_id_inst(o_id_inst), .o_id_rs1(o_id_rs1), .o_id_rs2(o_id_rs2), .o_id_rd(o_id_rd),
    .o_id_rs1_value(o_id_rs1_value), .o_id_rs2_value(o_id_rs2_value), .o_id_imm(o_id_imm),
    .o_id_alu_op(o_id_alu_op), .o_id_jal(o_id_jal), .o_id_jalr(o_id_jalr),
    .o_id_br_eq_ge(o_id_br_eq_ge), .o_id_br_ne_lt(o_id_br_ne_lt),
    .o_id_mem_type(o_id_mem_type), .o_id_mem_size(o_id_mem_size),
    .o_id_csr_access(o_id_csr_access), .o_id_ecall(o_id_ecall), .o_id_ebreak(o_id_ebreak),
    .o_id_mret(o_id_mret), .o_id_illegal(o_id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, inst;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_value, rs2_value, imm;
    logic [3:0]  alu_op;
    logic        jal, jalr, br_eq_ge, br_ne_lt;
    logic [1:0]  mem_type;
    logic [2:0]  mem_size, csr_access;
    logic        ecall, ebreak, mret, illegal;
  } exp_t;

  int          n_chk = 0, n_pass = 0;
  exp_t        m;
  bit          known;
  logic [31:0] rf [32];
  logic        t_rst, t_en, t_flush, t_stall, t_ifv, t_wbv;
  logic [4:0]  t_wbrd;
  logic [31:0] t_pc, t_inst, t_wbval, t_rv1, t_rv2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rdv(input logic [4:0] idx, input logic [31:0] rfv);
    if (idx == 0) return 32'd0;
    if (t_wbv && t_wbrd == idx) return t_wbval;
    return rfv;
  endfunction

  // Reference decode: classify by 7-bit opcode/mnemonic, immediates by field arithmetic
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] in);
    exp_t        e;
    bit          ok, u1, u2, ud;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] tab, ii, is, ib, ij;
    e = '0; ok = 1; u1 = 0; u2 = 0; ud = 0;
    f3 = in[14:12]; f7 = in[31:25];
    tab = 32'h98654320;  // funct3 -> ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND
    ii = $signed(in) >>> 20;
    is = (ii & ~32'h1F) | 32'(in[11:7]);
    ib = {in[31] ? 20'hFFFFF : 20'h0, in[7], in[30:25], in[11:8], 1'b0};
    ij = {in[31] ? 12'hFFF : 12'h0, in[19:12], in[20], in[30:21], 1'b0};
    case (in[6:0])
      7'h37: begin ud = 1; e.imm = in & 32'hFFFFF000; e.alu_op = 10; end
      7'h17: begin ud = 1; e.imm = in & 32'hFFFFF000; e.alu_op = 11; end
      7'h6F: begin ud = 1; e.imm = ij; e.alu_op = 12; e.jal = 1; end
      7'h67: begin ud = 1; u1 = 1; e.imm = ii; e.alu_op = 12; e.jalr = 1; ok = (f3 == 0); end
      7'h63: begin
        u1 = 1; u2 = 1; e.imm = ib;
        ok = f3 inside {0, 1, 4, 5, 6, 7};
        e.alu_op   = (f3 < 4) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
        e.br_eq_ge = f3 inside {0, 5, 7};
        e.br_ne_lt = f3 inside {1, 4, 6};
      end
      7'h03: begin
        ud = 1; u1 = 1; e.imm = ii; e.mem_type = 1; e.mem_size = f3;
        ok = !(f3 inside {3, 6, 7});
      end
      7'h23: begin u1 = 1; u2 = 1; e.imm = is; e.mem_type = 2; e.mem_size = f3; ok = (f3 <= 2); end
      7'h13: begin
        ud = 1; u1 = 1; e.imm = ii; e.alu_op = tab[f3*4 +: 4];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); if (f7 == 7'h20) e.alu_op = 7; end
      end
      7'h33: begin
        ud = 1; u1 = 1; u2 = 1; e.alu_op = tab[f3*4 +: 4];
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        if (f7 == 7'h20 && f3 == 0) e.alu_op = 1;
        if (f7 == 7'h20 && f3 == 5) e.alu_op = 7;
      end
      7'h0F: ok = (f3 == 0);
      7'h73: begin
        if (in == 32'h00000073)      e.ecall = 1;
        else if (in == 32'h00100073) e.ebreak = 1;
        else if (in == 32'h30200073) e.mret = 1;
        else if (f3 inside {1, 2, 3}) begin ud = 1; u1 = 1; e.csr_access = f3; end
        else if (f3 inside {5, 6, 7}) begin ud = 1; e.csr_access = f3; e.imm = 32'(in[19:15]); end
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin e = '0; e.illegal = 1; u1 = 0; u2 = 0; ud = 0; end
    e.valid = 1; e.pc = pc; e.inst = in;
    e.rs1 = u1 ? in[19:15] : 5'd0;
    e.rs2 = u2 ? in[24:20] : 5'd0;
    e.rd  = ud ? in[11:7]  : 5'd0;
    e.rs1_value = rdv(e.rs1, t_rv1);
    e.rs2_value = rdv(e.rs2, t_rv2);
    return e;
  endfunction

  function automatic logic [31:0] flags_of(input exp_t e);
    return 32'({e.jal, e.jalr, e.br_eq_ge, e.br_ne_lt, e.mem_type, e.mem_size,
                e.csr_access, e.ecall, e.ebreak, e.mret, e.illegal});
  endfunction

  task automatic cyc();
    @(negedge clk);
    i_rst_n = t_rst; i_enable = t_en; i_flush = t_flush; i_stall = t_stall;
    i_if_valid = t_ifv; i_if_pc = t_pc; i_if_inst = t_inst;
    i_rs1_value = t_rv1; i_rs2_value = t_rv2;
    i_wb_valid = t_wbv; i_wb_rd = t_wbrd; i_wb_value = t_wbval;
    #1;
    chk("o_rs1", 32'(o_rs1), 32'(t_inst[19:15]));
    chk("o_rs2", 32'(o_rs2), 32'(t_inst[24:20]));
    chk("o_if_stall", 32'(o_if_stall), 32'(t_stall));
    if (!t_rst || !t_en)  begin m = '0; known = 1; end
    else if (t_flush)     begin m.valid = 0; known = 0; end
    else if (!t_stall) begin
      m.valid = t_ifv;
      if (t_ifv) begin m = ref_decode(t_pc, t_inst); known = 1; end
    end
    @(posedge clk); #1;
    chk("valid", 32'(o_id_valid), 32'(m.valid));
    if (known) begin
      chk("pc", o_id_pc, m.pc);
      chk("inst", o_id_inst, m.inst);
      chk("rs1", 32'(o_id_rs1), 32'(m.rs1));
      chk("rs2", 32'(o_id_rs2), 32'(m.rs2));
      chk("rd", 32'(o_id_rd), 32'(m.rd));
      chk("rs1_value", o_id_rs1_value, m.rs1_value);
      chk("rs2_value", o_id_rs2_value, m.rs2_value);
      chk("imm", o_id_imm, m.imm);
      chk("alu_op", 32'(o_id_alu_op), 32'(m.alu_op));
      chk("flags", 32'({o_id_jal, o_id_jalr, o_id_br_eq_ge, o_id_br_ne_lt, o_id_mem_type,
                        o_id_mem_size, o_id_csr_access, o_id_ecall, o_id_ebreak, o_id_mret,
                        o_id_illegal}), flags_of(m));
    end
  endtask

  task automatic idle_defaults();
    t_rst = 1; t_en = 1; t_flush = 0; t_stall = 0; t_ifv = 0; t_wbv = 0; t_wbrd = 0; t_wbval = 0;
  endtask

  task automatic issue(input logic [31:0] inst);
    t_inst = inst; t_ifv = 1; t_pc = t_pc + 4;
    t_rv1 = rf[inst[19:15]]; t_rv2 = rf[inst[24:20]];
    cyc();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    logic [76:0] ops;
    int          k, s;
    ops = {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    x = $urandom;
    k = $urandom_range(0, 15);
    if (k < 11) x[6:0] = ops[k*7 +: 7];
    else if (k == 11) begin
      s = $urandom_range(0, 3);
      case (s)
        0: x = 32'h00000073;
        1: x = 32'h00100073;
        2: x = 32'h30200073;
        default: x = 32'h02000033;
      endcase
    end else if (k < 15) begin
      x[6:0]   = k[0] ? 7'h33 : 7'h13;
      x[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end
    return x;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd10;
    idle_defaults();
    t_pc = 32'h1000; t_inst = 32'h13; t_rv1 = 0; t_rv2 = 0;
    known = 0; m = '0;

    // reset state
    t_rst = 0; cyc(); cyc(); t_rst = 1;
    chk("reset_valid", 32'(o_id_valid), 32'd0);

    issue(32'hFFD08293);  // ADDI x5,x1,-3
    chk("addi_imm", o_id_imm, 32'hFFFFFFFD);
    chk("addi_rs1v", o_id_rs1_value, 32'd10);
    chk("addi_rd", 32'(o_id_rd), 32'd5);
    issue(32'h00317863);  // BGEU x2,x3,+16
    chk("bgeu_alu", 32'(o_id_alu_op), 32'd4);
    chk("bgeu_imm", o_id_imm, 32'd16);
    chk("bgeu_eqge", 32'(o_id_br_eq_ge), 32'd1);
    issue(32'h00310863);  // BEQ x2,x3,+16
    chk("beq_alu", 32'(o_id_alu_op), 32'd1);

    // stall holds for three cycles, release captures
    t_stall = 1;
    for (int i = 0; i < 3; i++) issue(rand_inst());
    chk("stall_hold_pc", o_id_pc, t_pc - 12);
    t_stall = 0;
    issue(32'h00A00513);  // ADDI x10,x0,10
    // flush during stall kills the held instruction
    t_stall = 1; t_flush = 1; issue(32'h00000013);
    chk("flush_valid", 32'(o_id_valid), 32'd0);
    t_stall = 0; t_flush = 0;
    issue(32'h00000013);
    t_ifv = 0; cyc();  // bubble
    issue(32'h40115093);  // SRAI
    t_rst = 0; cyc(); t_rst = 1;
    chk("midreset_imm", o_id_imm, 32'd0);
    issue(32'h00000013);
    t_en = 0; cyc(); t_en = 1;
    chk("disable_valid", 32'(o_id_valid), 32'd0);

    // write-back bypass
    t_wbv = 1; t_wbrd = 1; t_wbval = 32'h55;
    issue(32'hFFD08293);
    chk("bypass_rs1v", o_id_rs1_value, 32'h55);
    t_wbrd = 0; t_wbval = 32'h77;
    issue(32'h00000093);  // ADDI x1,x0,0
    chk("x0_rs1v", o_id_rs1_value, 32'd0);
    t_wbv = 0;

    issue(32'h00000000); chk("zero_illegal", 32'(o_id_illegal), 32'd1);
    issue(32'h02000033); chk("mul_illegal", 32'(o_id_illegal), 32'd1);
    issue(32'h30200073); chk("mret", 32'(o_id_mret), 32'd1);
    issue(32'h00100073); chk("ebreak", 32'(o_id_ebreak), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins     = rand_inst();
      t_rst   = ($urandom_range(0, 63) != 0);
      t_en    = ($urandom_range(0, 31) != 0);
      t_flush = ($urandom_range(0, 7) == 0);
      t_stall = ($urandom_range(0, 3) == 0);
      t_wbv   = ($urandom_range(0, 1) != 0);
      t_wbrd  = ($urandom_range(0, 1) != 0) ? ins[19:15] : 5'($urandom);
      t_wbval = $urandom;
      if (n % 97 == 0) rf[$urandom_range(0, 31)] = $urandom;
      if ($urandom_range(0, 3) == 0) begin t_ifv = 0; t_inst = ins; cyc(); end
      else begin
        t_pc = $urandom;
        issue(ins);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
